// File: rtl/lab_encoder_8x3_queue.sv
// Sequential 8-to-3 encoder with a request queue.
// Request pulses on Din are collected in a pending register. Each pending request
// produces one 3-bit code on A, handed off through a valid/ready handshake.
//
// Parameters:
//   RR      : 0 = fixed priority (highest index wins), 1 = round-robin
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   Din     : request lines; bit i requests code i (qualified by enable)
//   enable  : Din is sampled only while this is high
//   ready   : downstream accepts A this cycle
//   A       : encoded index being presented
//   valid   : A holds a request
//   busy    : a request is pending or presented
//   dup_err : sticky; a request arrived for an index that was already pending
module lab_encoder_8x3_queue #(
  parameter int unsigned RR = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Din,
  input  logic       enable,
  input  logic       ready,
  output logic [2:0] A,
  output logic       valid,
  output logic       busy,
  output logic       dup_err
);

  logic [7:0] pend_q, pend_d;
  logic [2:0] a_q, a_d;
  logic       valid_q, valid_d;
  logic       dup_q, dup_d;
  logic [2:0] last_q, last_d;

  logic [2:0] sel;
  logic       found;
  logic [2:0] idx;
  logic       load;
  logic [7:0] loadmask;
  logic [7:0] req;

  // Index selection over the pending set.
  always_comb begin
    sel   = 3'd0;
    found = 1'b0;
    idx   = 3'd0;
    if (RR == 0) begin
      // Later iterations overwrite earlier ones, so the highest set bit wins.
      for (int i = 0; i < 8; i++) begin
        if (pend_q[i]) sel = 3'(i);
      end
    end else begin
      // Scan upward from the slot after the last one served, wrapping mod 8.
      for (int i = 0; i < 8; i++) begin
        idx = last_q + 3'd1 + 3'(i);
        if (!found && pend_q[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    load     = (!valid_q || ready) && (pend_q != 8'h00);
    loadmask = load ? (8'h01 << sel) : 8'h00;
    req      = enable ? Din : 8'h00;
    // New requests are OR-ed in after the clear, so a same-cycle re-request survives.
    pend_d   = (pend_q & ~loadmask) | req;
    dup_d    = dup_q | ((req & pend_q & ~loadmask) != 8'h00);
    a_d      = a_q;
    valid_d  = valid_q;
    last_d   = last_q;
    if (load) begin
      a_d     = sel;
      valid_d = 1'b1;
      last_d  = sel;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 8'h00;
      a_q     <= 3'd0;
      valid_q <= 1'b0;
      dup_q   <= 1'b0;
      last_q  <= 3'd7;
    end else begin
      pend_q  <= pend_d;
      a_q     <= a_d;
      valid_q <= valid_d;
      dup_q   <= dup_d;
      last_q  <= last_d;
    end
  end

  assign A       = a_q;
  assign valid   = valid_q;
  assign dup_err = dup_q;
  assign busy    = (pend_q != 8'h00) || valid_q;

endmodule
